// File: rtl/access_control_fsm_if.sv
// Password-memory and user-side signals of the access controller.
// The master drives user data and memory read data; the slave is the controller.
interface access_control_fsm_if;
  logic [16:0] _Data_In;
  logic        _Data_In_Load;
  logic [15:0] _Memory_In;
  logic        Access_Grant;
  logic [15:0] Address;
  logic        wren;
  logic [15:0] Data_Out;

  modport master (
    output _Data_In, _Data_In_Load, _Memory_In,
    input  Access_Grant, Address, wren, Data_Out
  );

  modport slave (
    input  _Data_In, _Data_In_Load, _Memory_In,
    output Access_Grant, Address, wren, Data_Out
  );
endinterface

// File: rtl/access_control_fsm.sv
// Password-checking access controller: fetches the stored password from a
// synchronous memory, compares it with the user entry, locks out after repeated failures.
module access_control_fsm #(
  parameter logic [15:0] PASS_ADDR = 16'h0000,
  parameter int          MAX_FAIL  = 3
) (
  input  logic               clk,
  input  logic               rst,
  access_control_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    COMPARE = 3'd3,
    GRANTED = 3'd4,
    WRITE   = 3'd5,
    LOCKED  = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [1:0]  fail_count, fail_next;
  logic [2:0]  fail_inc;
  logic [15:0] pw_user, pw_user_next;
  logic [15:0] pw_mem, pw_mem_next;
  logic [15:0] data_out, data_out_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fail_count <= 2'd0;
      pw_user    <= 16'h0000;
      pw_mem     <= 16'h0000;
      data_out   <= 16'h0000;
    end else begin
      state      <= state_next;
      fail_count <= fail_next;
      pw_user    <= pw_user_next;
      pw_mem     <= pw_mem_next;
      data_out   <= data_out_next;
    end
  end

  // Widened so the increment is compared against MAX_FAIL before saturation
  assign fail_inc = {1'b0, fail_count} + 3'd1;

  always_comb begin
    state_next    = state;
    fail_next     = fail_count;
    pw_user_next  = pw_user;
    pw_mem_next   = pw_mem;
    data_out_next = data_out;
    case (state)
      IDLE: begin
        if (bus._Data_In_Load) begin
          pw_user_next = bus._Data_In[15:0];
          state_next   = FETCH;
        end
      end
      FETCH: state_next = LATCH;
      LATCH: begin
        pw_mem_next = bus._Memory_In;
        state_next  = COMPARE;
      end
      COMPARE: begin
        if (pw_user == pw_mem) begin
          fail_next  = 2'd0;
          state_next = GRANTED;
        end else begin
          fail_next  = (fail_count == 2'd3) ? 2'd3 : fail_inc[1:0];
          state_next = (32'(fail_inc) == MAX_FAIL) ? LOCKED : IDLE;
        end
      end
      GRANTED: begin
        if (bus._Data_In_Load) begin
          if (bus._Data_In[16]) begin
            data_out_next = bus._Data_In[15:0];
            pw_mem_next   = bus._Data_In[15:0];
            state_next    = WRITE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      WRITE:   state_next = GRANTED;
      LOCKED:  state_next = LOCKED;
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state register so reset clears them asynchronously
  assign bus.Access_Grant = (state == GRANTED) || (state == WRITE);
  assign bus.wren         = (state == WRITE);
  assign bus.Address      = PASS_ADDR;
  assign bus.Data_Out     = data_out;

endmodule

// File: tb/tb_access_control_fsm.sv
// Randomized bench for access_control_fsm against an attempt/outcome model
// that tracks pending attempts, session status and the stored password.
module tb_access_control_fsm;

  localparam int MAX_FAIL = 3;

  logic clk;
  logic rst;
  logic mem_load;
  logic [15:0] mem_word;

  access_control_fsm_if bus();

  access_control_fsm #(.PASS_ADDR(16'h0000), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-word password memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_load)          mem_word <= 16'h2456;
    else if (bus.wren)     mem_word <= bus.Data_Out;
    bus._Memory_In <= mem_word;
  end

  int checks;
  int failures;

  bit          m_granted, m_writing, m_locked;
  int          m_busy, m_fails;
  logic [15:0] m_attempt, m_pw, m_pending, m_dout;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("grant", 32'(bus.Access_Grant), 32'(m_granted));
    checkOutput("wren", 32'(bus.wren), 32'(m_writing));
    checkOutput("data_out", 32'(bus.Data_Out), 32'(m_dout));
    checkOutput("address", 32'(bus.Address), 32'h0000);
    checkOutput("fail_count", 32'(dut.fail_count), 32'(m_fails));
  endtask

  task automatic modelReset();
    m_granted = 0; m_writing = 0; m_locked = 0;
    m_busy = 0; m_fails = 0; m_dout = 16'h0000;
  endtask

  // One clock edge of the behaviour: attempts resolve three edges after acceptance
  task automatic modelStep(input logic load, input logic [16:0] data);
    if (m_locked) begin
    end else if (m_writing) begin
      m_writing = 0;
      m_pw = m_pending;
    end else if (m_granted) begin
      if (load) begin
        if (data[16]) begin
          m_dout = data[15:0];
          m_pending = data[15:0];
          m_writing = 1;
        end else begin
          m_granted = 0;
        end
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_attempt == m_pw) begin
          m_fails = 0;
          m_granted = 1;
        end else begin
          m_fails = (m_fails < 3) ? m_fails + 1 : 3;
          if (m_fails == MAX_FAIL) m_locked = 1;
        end
      end
    end else if (load) begin
      m_attempt = data[15:0];
      m_busy = 3;
    end
  endtask

  task automatic applyStimulus(input logic load, input logic [16:0] data);
    bus._Data_In_Load = load;
    bus._Data_In = data;
    @(posedge clk);
    modelStep(load, data);
    #1;
    checkAll();
  endtask

  // Asserts reset mid-cycle and checks outputs clear before any clock edge
  task automatic doReset();
    bus._Data_In_Load = 1'b0;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;
  endtask

  task automatic login(input logic [15:0] pw);
    applyStimulus(1'b1, {1'b0, pw});
    repeat (3) applyStimulus(1'b0, 17'h00000);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    mem_load = 1'b1;
    bus._Data_In = '0;
    bus._Data_In_Load = 1'b0;
    m_pw = 16'h2456;
    m_pending = 16'h0000;
    m_attempt = 16'h0000;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll();
    mem_load = 1'b0;
    rst = 1'b0;

    login(16'h2456);
    checkOutput("correct_pw_grant", 32'(bus.Access_Grant), 32'd1);
    applyStimulus(1'b1, 17'h00000);
    checkOutput("logout_drop", 32'(bus.Access_Grant), 32'd0);

    login(16'h1476);
    checkOutput("wrong_pw_no_grant", 32'(bus.Access_Grant), 32'd0);
    checkOutput("wrong_pw_fail1", 32'(dut.fail_count), 32'd1);
    login(16'h2456);
    checkOutput("retry_grant", 32'(bus.Access_Grant), 32'd1);
    applyStimulus(1'b1, 17'h00000);

    repeat (3) login(16'h1476);
    checkOutput("lock_fail3", 32'(dut.fail_count), 32'd3);
    login(16'h2456);
    checkOutput("locked_no_grant", 32'(bus.Access_Grant), 32'd0);
    doReset();
    checkOutput("reset_unlocks", 32'(dut.fail_count), 32'd0);

    login(16'h2456);
    applyStimulus(1'b1, 17'h1ABCD);
    checkOutput("write_wren", 32'(bus.wren), 32'd1);
    checkOutput("write_data", 32'(bus.Data_Out), 32'h0000ABCD);
    applyStimulus(1'b0, 17'h00000);
    checkOutput("write_one_cycle", 32'(bus.wren), 32'd0);
    checkOutput("write_keeps_grant", 32'(bus.Access_Grant), 32'd1);
    applyStimulus(1'b1, 17'h00000);
    login(16'hABCD);
    checkOutput("new_pw_grant", 32'(bus.Access_Grant), 32'd1);

    applyStimulus(1'b1, 17'h15A5A);
    doReset();
    checkOutput("reset_in_write", 32'(bus.wren), 32'd0);
    login(16'hABCD);
    checkOutput("aborted_write_kept_pw", 32'(bus.Access_Grant), 32'd1);
    applyStimulus(1'b1, 17'h00000);

    for (int i = 0; i < 1500; i++) begin
      logic        ld;
      logic [16:0] d;
      if ((m_locked && $urandom_range(7) == 0) || $urandom_range(199) == 0) begin
        doReset();
      end else begin
        ld = 1'($urandom_range(1));
        d[16] = 1'($urandom_range(1));
        d[15:0] = ($urandom_range(2) != 0) ? m_pw : 16'($urandom);
        applyStimulus(ld, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
